// File: rtl/prelude_pkg.sv
// prelude_pkg
// Shared definitions for the Prelude run/halt/step and program-load
// controller: command opcodes, the controller state encoding and the
// default instruction-memory address width.
// No ports; imported with "import prelude_pkg::*".

package prelude_pkg;

  // Default instruction-memory address width (256 locations).
  localparam int PRELUDE_ADDR_W = 8;

  // Command opcodes carried on the byte-wide command stream.
  localparam logic [7:0] CMD_HALT   = 8'h01;
  localparam logic [7:0] CMD_RUN    = 8'h02;
  localparam logic [7:0] CMD_STEP   = 8'h03;
  localparam logic [7:0] CMD_LOAD   = 8'h04;
  localparam logic [7:0] CMD_RESET  = 8'h05;
  localparam logic [7:0] CMD_CLRERR = 8'h06;

  // Controller states. The LD_* states consume payload bytes of a LOAD;
  // STEP and RST are the only states that refuse command bytes.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LD_ADDR = 3'd1,
    LD_LEN  = 3'd2,
    LD_DATA = 3'd3,
    STEP    = 3'd4,
    RST     = 3'd5
  } ctrl_state_t;

endpackage

// File: rtl/prelude_if.sv
// prelude_if
// Bundles the command handshake, core control and instruction-memory write
// port of the Prelude controller.
// Parameter:
//   ADDR_W     instruction-memory address width
// Signals:
//   cmd_data   command/payload byte            (host -> controller)
//   cmd_valid  byte present                    (host -> controller)
//   cmd_ready  controller accepts byte         (controller -> host)
//   cpu_en     core clock-enable               (controller -> core)
//   cpu_reset  synchronous reset to core PC    (controller -> core)
//   mem_we     instruction-memory write strobe (controller -> memory)
//   mem_addr   write address                   (controller -> memory)
//   mem_wdata  write data                      (controller -> memory)
//   running    free-run mode active            (status)
//   load_done  pulse with the last LOAD write  (status)
//   err        sticky unknown-opcode flag      (status)
// Modports:
//   master  host/observer side (drives cmd_data, cmd_valid)
//   slave   controller side (prelude_ctrl)

interface prelude_if #(
  parameter int ADDR_W = 8
) ();

  logic [7:0]        cmd_data;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cpu_en;
  logic              cpu_reset;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              running;
  logic              load_done;
  logic              err;

  modport master (
    output cmd_data,
    output cmd_valid,
    input  cmd_ready,
    input  cpu_en,
    input  cpu_reset,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    input  running,
    input  load_done,
    input  err
  );

  modport slave (
    input  cmd_data,
    input  cmd_valid,
    output cmd_ready,
    output cpu_en,
    output cpu_reset,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    output running,
    output load_done,
    output err
  );

endinterface

// File: rtl/prelude_ctrl.sv
// prelude_ctrl
// Run/halt/step and program-load controller for the Prelude core. Decodes a
// byte-wide command stream, drives the core clock-enable and PC reset, and
// owns the instruction-memory write port while a LOAD is in progress.
// Parameters:
//   ADDR_W      instruction-memory address width
//   RST_CYCLES  cycles cpu_reset is held for a RESET command (>= 1)
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high reset
//   bus    prelude_if.slave: command handshake, core control, memory write
//          port and status flags

module prelude_ctrl
  import prelude_pkg::*;
#(
  parameter int ADDR_W     = PRELUDE_ADDR_W,
  parameter int RST_CYCLES = 2
) (
  input logic      clk,
  input logic      reset,
  prelude_if.slave bus
);

  localparam int CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  ctrl_state_t       r_state;
  ctrl_state_t       w_nextState;

  logic              r_running;
  logic              r_err;
  logic              r_cpuResetHold;
  logic              r_memWe;
  logic [ADDR_W-1:0] r_memAddr;
  logic [7:0]        r_memWdata;
  logic              r_loadDone;
  logic [ADDR_W-1:0] r_addr;
  logic [8:0]        r_remain;
  logic [CNT_W-1:0]  r_rstCnt;

  logic              w_cmdReady;
  logic              w_cpuEn;
  logic              w_cpuReset;
  logic              w_accept;

  // State register. An asynchronous reset aborts any load or step in
  // progress and parks the controller in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and state-derived outputs. cmd_ready is only dropped in STEP
  // and RST so the host can stream a whole LOAD back-to-back. The core is
  // enabled by free-run mode in IDLE or by the single STEP cycle; every LD_*
  // state and RST keep it stopped. cpu_reset is the post-reset hold OR'd
  // with the RST window.
  always_comb begin
    w_nextState = r_state;
    w_cmdReady  = 1'b0;
    w_cpuEn     = 1'b0;
    w_cpuReset  = r_cpuResetHold;
    case (r_state)
      IDLE: begin
        w_cmdReady = 1'b1;
        w_cpuEn    = r_running;
        if (bus.cmd_valid) begin
          case (bus.cmd_data)
            CMD_STEP:  if (!r_running) w_nextState = STEP;
            CMD_LOAD:  w_nextState = LD_ADDR;
            CMD_RESET: w_nextState = RST;
            default:   w_nextState = IDLE;
          endcase
        end
      end
      LD_ADDR: begin
        w_cmdReady = 1'b1;
        if (bus.cmd_valid) w_nextState = LD_LEN;
      end
      LD_LEN: begin
        w_cmdReady = 1'b1;
        if (bus.cmd_valid) w_nextState = LD_DATA;
      end
      LD_DATA: begin
        w_cmdReady = 1'b1;
        if (bus.cmd_valid && (r_remain == 9'd1)) w_nextState = IDLE;
      end
      STEP: begin
        w_cpuEn     = 1'b1;
        w_nextState = IDLE;
      end
      RST: begin
        w_cpuReset = 1'b1;
        if (r_rstCnt == '0) w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
    w_accept = bus.cmd_valid & w_cmdReady;
  end

  // Command side effects and the load datapath. Payload bytes are only ever
  // interpreted by the LD_* branches, so opcode-valued data is written as
  // data. The remaining-byte counter is 9 bits so a length byte of 0 can
  // stand for a full 256-byte load. Writes are registered: each accepted
  // data byte produces exactly one mem_we cycle, and load_done rides along
  // with the final one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_running      <= 1'b0;
      r_err          <= 1'b0;
      r_cpuResetHold <= 1'b1;
      r_memWe        <= 1'b0;
      r_memAddr      <= '0;
      r_memWdata     <= 8'h00;
      r_loadDone     <= 1'b0;
      r_addr         <= '0;
      r_remain       <= 9'd0;
      r_rstCnt       <= '0;
    end else begin
      r_memWe    <= 1'b0;
      r_loadDone <= 1'b0;

      if ((r_state == RST) && (r_rstCnt != '0)) begin
        r_rstCnt <= r_rstCnt - CNT_W'(1);
      end

      if (w_accept) begin
        case (r_state)
          IDLE: begin
            case (bus.cmd_data)
              CMD_HALT: begin
                r_running <= 1'b0;
              end
              CMD_RUN: begin
                r_running      <= 1'b1;
                r_cpuResetHold <= 1'b0;
              end
              CMD_STEP: begin
                r_cpuResetHold <= 1'b0;
              end
              CMD_LOAD: begin
                r_running      <= 1'b0;
                r_cpuResetHold <= 1'b0;
              end
              CMD_RESET: begin
                r_running <= 1'b0;
                r_rstCnt  <= CNT_W'(RST_CYCLES - 1);
              end
              CMD_CLRERR: begin
                r_err <= 1'b0;
              end
              default: begin
                r_err <= 1'b1;
              end
            endcase
          end
          LD_ADDR: begin
            r_addr <= ADDR_W'(bus.cmd_data);
          end
          LD_LEN: begin
            r_remain <= (bus.cmd_data == 8'h00) ? 9'd256 : {1'b0, bus.cmd_data};
          end
          LD_DATA: begin
            r_memWe    <= 1'b1;
            r_memAddr  <= r_addr;
            r_memWdata <= bus.cmd_data;
            r_addr     <= r_addr + ADDR_W'(1);
            r_remain   <= r_remain - 9'd1;
            if (r_remain == 9'd1) r_loadDone <= 1'b1;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign bus.cmd_ready = w_cmdReady;
  assign bus.cpu_en    = w_cpuEn;
  assign bus.cpu_reset = w_cpuReset;
  assign bus.mem_we    = r_memWe;
  assign bus.mem_addr  = r_memAddr;
  assign bus.mem_wdata = r_memWdata;
  assign bus.running   = r_running;
  assign bus.load_done = r_loadDone;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_prelude_ctrl.sv
// tb_prelude_ctrl
// Self-checking bench for prelude_ctrl. Expected memory writes are queued as
// payload bytes are driven and compared when the controller strobes mem_we.

module tb_prelude_ctrl;
  import prelude_pkg::*;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic       last;
  } wr_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  int errors = 0;
  int checks = 0;
  int enCount = 0;
  int writeCount = 0;
  int doneCount = 0;

  wr_t        expQ[$];
  logic [7:0] payload[$];

  always #5 clk = ~clk;

  prelude_if #(.ADDR_W(8)) ifc ();

  prelude_ctrl #(
    .ADDR_W    (8),
    .RST_CYCLES(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Counts core edges that the controller enables (value seen at the edge).
  always @(posedge clk) begin
    if (ifc.cpu_en === 1'b1) enCount++;
  end

  // Memory-write scoreboard: every strobe must match the oldest queued entry.
  always @(negedge clk) begin
    wr_t e;
    if (!reset) begin
      if (ifc.mem_we === 1'b1) begin
        writeCount++;
        checkOutput("wrExpected", 32'(expQ.size() != 0), 1);
        if (expQ.size() != 0) begin
          e = expQ.pop_front();
          checkOutput("wrAddr", ifc.mem_addr, e.addr);
          checkOutput("wrData", ifc.mem_wdata, e.data);
          checkOutput("wrDone", ifc.load_done, e.last);
        end
      end
      if (ifc.load_done === 1'b1) begin
        doneCount++;
        checkOutput("doneNeedsWe", ifc.mem_we, 1);
      end
    end
  end

  // Present one byte, wait (bounded) for ready, and release after the
  // accepting edge. Returns on the falling edge after acceptance.
  task automatic applyStimulus(input logic [7:0] b, input int maxGap);
    int n;
    if (maxGap > 0) repeat ($urandom_range(maxGap, 0)) @(negedge clk);
    ifc.cmd_data  = b;
    ifc.cmd_valid = 1'b1;
    n = 0;
    while (ifc.cmd_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) checkOutput("readyTimeout", n, 0);
    @(posedge clk);
    @(negedge clk);
    ifc.cmd_valid = 1'b0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".cmdReady"}, ifc.cmd_ready, 1);
    checkOutput({tag, ".cpuEn"}, ifc.cpu_en, 0);
    checkOutput({tag, ".cpuReset"}, ifc.cpu_reset, 1);
    checkOutput({tag, ".memWe"}, ifc.mem_we, 0);
    checkOutput({tag, ".memAddr"}, ifc.mem_addr, 0);
    checkOutput({tag, ".memWdata"}, ifc.mem_wdata, 0);
    checkOutput({tag, ".running"}, ifc.running, 0);
    checkOutput({tag, ".loadDone"}, ifc.load_done, 0);
    checkOutput({tag, ".err"}, ifc.err, 0);
  endtask

  // Full LOAD of the bytes in payload, queuing each expected write.
  task automatic doLoad(input logic [7:0] start, input int maxGap);
    int         len;
    logic [7:0] lenByte;
    len     = payload.size();
    lenByte = (len == 256) ? 8'h00 : 8'(len);
    applyStimulus(CMD_LOAD, maxGap);
    checkOutput("ldCpuEn", ifc.cpu_en, 0);
    checkOutput("ldRunning", ifc.running, 0);
    applyStimulus(start, maxGap);
    applyStimulus(lenByte, maxGap);
    for (int k = 0; k < len; k++) begin
      expQ.push_back('{addr: start + 8'(k), data: payload[k], last: (k == len - 1)});
      applyStimulus(payload[k], maxGap);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int e0;
    int d0;
    int w0;

    ifc.cmd_valid = 1'b0;
    ifc.cmd_data  = 8'h00;
    reset         = 1'b1;
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    reset = 1'b0;
    @(negedge clk);
    checkOutput("cpuResetHeld", ifc.cpu_reset, 1);

    // RUN, then HALT accepted ten edges later: ten enabled core edges.
    applyStimulus(CMD_RUN, 0);
    e0 = enCount;
    checkOutput("runCpuReset", ifc.cpu_reset, 0);
    checkOutput("runCpuEn", ifc.cpu_en, 1);
    checkOutput("runRunning", ifc.running, 1);
    repeat (9) @(negedge clk);
    applyStimulus(CMD_HALT, 0);
    checkOutput("runEdges", enCount - e0, 10);
    checkOutput("haltCpuEn", ifc.cpu_en, 0);
    checkOutput("haltRunning", ifc.running, 0);
    repeat (3) @(negedge clk);
    checkOutput("haltEdges", enCount - e0, 10);

    // Three single steps from halted.
    e0 = enCount;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(CMD_STEP, 0);
      checkOutput("stepCpuEn", ifc.cpu_en, 1);
      checkOutput("stepReady", ifc.cmd_ready, 0);
      @(negedge clk);
      checkOutput("stepCpuEnOff", ifc.cpu_en, 0);
      checkOutput("stepReadyBack", ifc.cmd_ready, 1);
    end
    repeat (2) @(negedge clk);
    checkOutput("stepEdges", enCount - e0, 3);

    // RESET command holds cpu_reset for two cycles.
    applyStimulus(CMD_RESET, 0);
    checkOutput("rstCpuReset0", ifc.cpu_reset, 1);
    checkOutput("rstReady", ifc.cmd_ready, 0);
    checkOutput("rstCpuEn", ifc.cpu_en, 0);
    @(negedge clk);
    checkOutput("rstCpuReset1", ifc.cpu_reset, 1);
    @(negedge clk);
    checkOutput("rstCpuResetEnd", ifc.cpu_reset, 0);
    checkOutput("rstReadyBack", ifc.cmd_ready, 1);

    // Short load wrapping 0xFF -> 0x00, with an opcode-valued data byte.
    payload = '{8'h11, 8'h01, 8'h22};
    d0 = doneCount;
    doLoad(8'hFE, 0);
    repeat (3) @(negedge clk);
    checkOutput("ld3Drained", expQ.size(), 0);
    checkOutput("ld3Done", doneCount - d0, 1);
    checkOutput("ld3Running", ifc.running, 0);

    // Length 0 means 256 bytes; valid is gapped randomly.
    payload.delete();
    for (int i = 0; i < 256; i++) payload.push_back(8'($urandom_range(255, 0)));
    d0 = doneCount;
    w0 = writeCount;
    doLoad(8'h37, 2);
    repeat (3) @(negedge clk);
    checkOutput("ld256Writes", writeCount - w0, 256);
    checkOutput("ld256Drained", expQ.size(), 0);
    checkOutput("ld256Done", doneCount - d0, 1);

    // LOAD issued while running stops the core for good.
    applyStimulus(CMD_RUN, 0);
    checkOutput("preLdCpuEn", ifc.cpu_en, 1);
    repeat (4) @(negedge clk);
    payload = '{8'hAA, 8'hBB};
    doLoad(8'h10, 0);
    repeat (4) @(negedge clk);
    checkOutput("postLdCpuEn", ifc.cpu_en, 0);
    checkOutput("postLdRunning", ifc.running, 0);
    checkOutput("postLdDrained", expQ.size(), 0);

    // Unknown opcode, recovery and CLRERR.
    applyStimulus(8'h7F, 0);
    checkOutput("errSet", ifc.err, 1);
    checkOutput("errRunning", ifc.running, 0);
    applyStimulus(CMD_RUN, 0);
    checkOutput("errRunWorks", ifc.running, 1);
    checkOutput("errSticky", ifc.err, 1);
    applyStimulus(CMD_CLRERR, 0);
    checkOutput("errCleared", ifc.err, 0);
    applyStimulus(CMD_HALT, 0);
    checkOutput("errHalt", ifc.running, 0);

    // Asynchronous reset in the middle of LD_DATA.
    applyStimulus(CMD_LOAD, 0);
    applyStimulus(8'h40, 0);
    applyStimulus(8'h05, 0);
    expQ.push_back('{addr: 8'h40, data: 8'h5A, last: 1'b0});
    applyStimulus(8'h5A, 0);
    expQ.push_back('{addr: 8'h41, data: 8'hA5, last: 1'b0});
    applyStimulus(8'hA5, 0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 checkResetValues("midLoad");
    checkOutput("midLoadDrained", expQ.size(), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    applyStimulus(CMD_RUN, 0);
    checkOutput("afterRstRun", ifc.running, 1);
    checkOutput("afterRstNoWe", ifc.mem_we, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
